// File: rtl/alu_ctrl_pkg.sv
// Shared constants, state encoding and instruction field helpers for the
// 12-bit ALU issue controller.
package alu_ctrl_pkg;

  localparam int WORD_W   = 12;
  localparam int REG_W    = 3;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 4;

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDC = 3'd2;
  localparam logic [2:0] OP_UMUL = 3'd3;
  localparam logic [2:0] OP_SMUL = 3'd4;
  localparam logic [2:0] OP_FADD = 3'd5;
  localparam logic [2:0] OP_FMUL = 3'd6;
  localparam logic [2:0] OP_CMP  = 3'd7;

  localparam int OP_LSB  = 9;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic [2:0] f_op(input logic [WORD_W-1:0] i);
    return i[OP_LSB +: 3];
  endfunction

  function automatic logic [REG_W-1:0] f_rd(input logic [WORD_W-1:0] i);
    return i[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] f_rs1(input logic [WORD_W-1:0] i);
    return i[RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] f_rs2(input logic [WORD_W-1:0] i);
    return i[RS2_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, load and result channels of the ALU issue controller.
// Instruction handshake: a transfer happens on a rising edge where instr_valid and instr_ready are both high.
interface alu_issue_ctrl_if import alu_ctrl_pkg::*; ();

  logic              instr_valid;
  logic [WORD_W-1:0] instr;
  logic              instr_ready;
  logic              ld_valid;
  logic [REG_W-1:0]  ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic              res_valid;
  logic [REG_W-1:0]  res_rd;
  logic [WORD_W-1:0] res_data;

  modport master (
    output instr_valid, instr, ld_valid, ld_addr, ld_data,
    input  instr_ready, res_valid, res_rd, res_data
  );

  modport slave (
    input  instr_valid, instr, ld_valid, ld_addr, ld_data,
    output instr_ready, res_valid, res_rd, res_data
  );

endinterface

// File: rtl/regfile8x12.sv
// 8x12 register file: writeback and load lanes (writeback has priority on the
// same entry), three combinational read ports.
module regfile8x12 import alu_ctrl_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [WORD_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [REG_W-1:0]  ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  input  logic [REG_W-1:0]  rs1_addr,
  output logic [WORD_W-1:0] rs1_data,
  input  logic [REG_W-1:0]  rs2_addr,
  output logic [WORD_W-1:0] rs2_data,
  input  logic [REG_W-1:0]  dbg_addr,
  output logic [WORD_W-1:0] dbg_data
);

  logic [WORD_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_en && wb_addr == REG_W'(i))      regs[i] <= wb_data;
        else if (ld_en && ld_addr == REG_W'(i)) regs[i] <= ld_data;
      end
    end
  end

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: latches an instruction, drives registered ALU inputs for
// SETTLE cycles, then writes the ALU result back to the destination register.
module alu_issue_ctrl import alu_ctrl_pkg::*; #(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus,
  output logic [2:0]        alu_op,
  output logic [WORD_W-1:0] alu_op1,
  output logic [WORD_W-1:0] alu_op2,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [REG_W-1:0]  dbg_addr,
  output logic [WORD_W-1:0] dbg_data,
  output state_t            dbg_state
);

  state_t            state, state_n;
  logic [WORD_W-1:0] instr_q;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] rs1_data, rs2_data;
  logic              wb_en, ld_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.instr_valid) state_n = ST_READ;
      ST_READ: state_n = ST_EXEC;
      ST_EXEC: if (cnt == '0) state_n = ST_WB;
      ST_WB:   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q       <= '0;
      cnt           <= '0;
      alu_op        <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_rd    <= '0;
      bus.res_data  <= '0;
    end else begin
      if (state == ST_IDLE && bus.instr_valid) instr_q <= bus.instr;
      // Operands are snapshotted here; later loads to rs1/rs2 cannot disturb the op.
      if (state == ST_READ) begin
        alu_op  <= f_op(instr_q);
        alu_op1 <= rs1_data;
        alu_op2 <= rs2_data;
        cnt     <= CNT_W'(SETTLE - 1);
      end
      if (state == ST_EXEC && cnt != '0) cnt <= cnt - 1'b1;
      if (state == ST_EXEC && cnt == '0) begin
        bus.res_rd   <= f_rd(instr_q);
        bus.res_data <= alu_out;
      end
      bus.res_valid <= (state == ST_EXEC && cnt == '0);
    end
  end

  // A load aimed at rd during WB is dropped; loads elsewhere proceed alongside.
  assign wb_en = (state == ST_WB);
  assign ld_en = bus.ld_valid && !(wb_en && bus.ld_addr == bus.res_rd);

  regfile8x12 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (bus.res_rd),
    .wb_data  (bus.res_data),
    .ld_en    (ld_en),
    .ld_addr  (bus.ld_addr),
    .ld_data  (bus.ld_data),
    .rs1_addr (f_rs1(instr_q)),
    .rs1_data (rs1_data),
    .rs2_addr (f_rs2(instr_q)),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign bus.instr_ready = (state == ST_IDLE) && !rst;
  assign dbg_state       = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 12-bit ALU, SETTLE=2.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  logic              clk;
  logic              rst;
  logic [2:0]        alu_op;
  logic [WORD_W-1:0] alu_op1, alu_op2, alu_out;
  logic [REG_W-1:0]  dbg_addr;
  logic [WORD_W-1:0] dbg_data;
  state_t            dbg_state;
  int                checks;
  int                errors;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .alu_op    (alu_op),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_out   (alu_out),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- behavioural ALU: integer ops truncate to 8 bits ----
  function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [11:0] a,
                                            input logic [11:0] b);
    logic [15:0] t;
    case (op)
      3'd1:    t = 16'(a[7:0]) + 16'(b[7:0]);
      3'd2:    t = 16'(a[7:0]) + 16'(b[7:0]) + 16'd1;
      3'd3:    t = 16'(a[7:0]) * 16'(b[7:0]);
      3'd4:    t = 16'($signed(a[7:0]) * $signed(b[7:0]));
      3'd5:    t = 16'(a ^ b);
      3'd6:    t = 16'(a & b);
      3'd7:    t = (a < b) ? 16'd1 : 16'd0;
      default: t = 16'd0;
    endcase
    return {4'h0, t[7:0]};
  endfunction

  assign alu_out = alu_model(alu_op, alu_op1, alu_op2);

  // ---- driver tasks (called just after a rising edge) ----
  task automatic do_load(input logic [2:0] a, input logic [11:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [11:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Offers one instruction, then records what happens during cycles 1..10
  // after the accepting edge. An optional load is driven in cycle ld_cyc.
  task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input int ld_cyc, input logic [2:0] ld_a,
                        input logic [11:0] ld_d, output int wb_cyc, output int nwb,
                        output logic [2:0] o_rd, output logic [11:0] o_data,
                        output int rdy_cyc, output logic timeout);
    wb_cyc = 0; nwb = 0; rdy_cyc = 0; o_rd = '0; o_data = '0; timeout = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = {op, rd, rs1, rs2};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        timeout = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    if (timeout) return;
    for (int c = 1; c <= 10; c++) begin
      bus.ld_valid = (c == ld_cyc);
      bus.ld_addr  = ld_a;
      bus.ld_data  = ld_d;
      @(negedge clk);
      if (bus.res_valid) begin
        nwb++;
        if (wb_cyc == 0) begin
          wb_cyc = c;
          o_rd   = bus.res_rd;
          o_data = bus.res_data;
        end
      end
      if (bus.instr_ready && rdy_cyc == 0) rdy_cyc = c;
      @(posedge clk); #1;
    end
    bus.ld_valid = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    logic [11:0] d;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_in_rst got %0b want 0", bus.instr_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      checks++;
      if (d !== 12'h000) begin
        errors++; $display("FAIL reset_reg%0d got %03h want 000", i, d);
      end
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b want 1", bus.instr_ready);
    end
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_res_valid got %0b want 0", bus.res_valid);
    end
    checks++;
    if ({alu_op, alu_op1, alu_op2, bus.res_rd, bus.res_data} !== 42'd0) begin
      errors++; $display("FAIL reset_outputs got nonzero want 0");
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d want 0", dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int wb_cyc, nwb, rdy_cyc; logic [2:0] o_rd; logic [11:0] o_data, d; logic to;
    do_load(3'd1, 12'h012);
    do_load(3'd2, 12'h034);
    run_op(3'd1, 3'd3, 3'd1, 3'd2, 0, 3'd0, 12'h000, wb_cyc, nwb, o_rd, o_data, rdy_cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL add_accept got timeout want accept"); end
    checks++;
    if (wb_cyc != 4 || nwb != 1) begin
      errors++; $display("FAIL add_latency got cyc=%0d n=%0d want cyc=4 n=1", wb_cyc, nwb);
    end
    checks++;
    if (o_rd !== 3'd3 || o_data !== 12'h046) begin
      errors++; $display("FAIL add_result got rd=%0d data=%03h want rd=3 data=046", o_rd, o_data);
    end
    checks++;
    if (rdy_cyc != 5) begin
      errors++; $display("FAIL add_ready_return got %0d want 5", rdy_cyc);
    end
    read_reg(3'd3, d);
    checks++;
    if (d !== 12'h046) begin errors++; $display("FAIL add_r3 got %03h want 046", d); end
  endtask

  task automatic test_addc();
    int wb_cyc, nwb, rdy_cyc; logic [2:0] o_rd; logic [11:0] o_data, d; logic to;
    do_load(3'd1, 12'h0FF);
    do_load(3'd2, 12'h001);
    run_op(3'd2, 3'd4, 3'd1, 3'd2, 0, 3'd0, 12'h000, wb_cyc, nwb, o_rd, o_data, rdy_cyc, to);
    checks++;
    if (to || wb_cyc != 4 || o_rd !== 3'd4 || o_data !== 12'h001) begin
      errors++;
      $display("FAIL addc_result got to=%0b cyc=%0d rd=%0d data=%03h want cyc=4 rd=4 data=001",
               to, wb_cyc, o_rd, o_data);
    end
    read_reg(3'd4, d);
    checks++;
    if (d !== 12'h001) begin errors++; $display("FAIL addc_r4 got %03h want 001", d); end
  endtask

  task automatic test_hold_valid();
    int nwb, wb_cyc; logic [11:0] d; logic to; logic exp_rdy;
    do_load(3'd5, 12'h00C);
    do_load(3'd6, 12'h00A);
    bus.instr_valid = 1'b1;
    bus.instr       = {3'd3, 3'd5, 3'd5, 3'd6};
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_ready) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL hold_accept got timeout want accept"); end
    @(posedge clk); #1;
    nwb = 0; wb_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_rdy = (c >= 5);
      checks++;
      if (bus.instr_ready !== exp_rdy) begin
        errors++; $display("FAIL hold_ready_c%0d got %0b want %0b", c, bus.instr_ready, exp_rdy);
      end
      if (bus.res_valid) begin
        nwb++;
        if (wb_cyc == 0) wb_cyc = c;
        checks++;
        if (bus.res_data !== 12'h078) begin
          errors++; $display("FAIL hold_result got %03h want 078", bus.res_data);
        end
      end
      if (c == 4) bus.instr_valid = 1'b0;
    end
    checks++;
    if (nwb != 1 || wb_cyc != 4) begin
      errors++; $display("FAIL hold_single_issue got n=%0d cyc=%0d want n=1 cyc=4", nwb, wb_cyc);
    end
    read_reg(3'd5, d);
    checks++;
    if (d !== 12'h078) begin errors++; $display("FAIL hold_r5 got %03h want 078", d); end
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    int wb_cyc, nwb, rdy_cyc; logic [2:0] o_rd; logic [11:0] o_data, d; logic to;
    do_load(3'd1, 12'h003);
    do_load(3'd6, 12'h004);
    // load to rs2 during EXEC must not disturb the in-flight add
    run_op(3'd1, 3'd2, 3'd1, 3'd6, 2, 3'd6, 12'hABC, wb_cyc, nwb, o_rd, o_data, rdy_cyc, to);
    checks++;
    if (to || wb_cyc != 4 || o_data !== 12'h007) begin
      errors++; $display("FAIL coll_exec_result got to=%0b cyc=%0d data=%03h want cyc=4 data=007",
                         to, wb_cyc, o_data);
    end
    read_reg(3'd6, d);
    checks++;
    if (d !== 12'hABC) begin errors++; $display("FAIL coll_r6 got %03h want abc", d); end
    // load to rd during WB loses to the writeback
    run_op(3'd1, 3'd2, 3'd1, 3'd1, 4, 3'd2, 12'h555, wb_cyc, nwb, o_rd, o_data, rdy_cyc, to);
    read_reg(3'd2, d);
    checks++;
    if (to || d !== 12'h006) begin errors++; $display("FAIL coll_wb_rd got %03h want 006", d); end
    // load elsewhere during WB completes; R0 is writable
    run_op(3'd1, 3'd0, 3'd1, 3'd1, 4, 3'd7, 12'h123, wb_cyc, nwb, o_rd, o_data, rdy_cyc, to);
    read_reg(3'd7, d);
    checks++;
    if (to || d !== 12'h123) begin errors++; $display("FAIL coll_wb_other got %03h want 123", d); end
    read_reg(3'd0, d);
    checks++;
    if (d !== 12'h006) begin errors++; $display("FAIL coll_r0 got %03h want 006", d); end
  endtask

  task automatic test_reset_mid();
    int nwb, wb_cyc, rdy_cyc; logic [2:0] o_rd; logic [11:0] o_data, d; logic to;
    do_load(3'd1, 12'h005);
    do_load(3'd2, 12'h003);
    bus.instr_valid = 1'b1;
    bus.instr       = {3'd1, 3'd7, 3'd1, 3'd2};
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_ready) begin to = 1'b0; break; end
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (to || bus.res_valid !== 1'b0 || bus.instr_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_during got to=%0b rv=%0b rdy=%0b want 0 0 0",
                         to, bus.res_valid, bus.instr_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    nwb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.res_valid) nwb++;
    end
    checks++;
    if (nwb != 0) begin errors++; $display("FAIL rstmid_no_wb got %0d pulses want 0", nwb); end
    read_reg(3'd7, d);
    checks++;
    if (d !== 12'h000) begin errors++; $display("FAIL rstmid_rd got %03h want 000", d); end
    @(posedge clk); #1;
    do_load(3'd1, 12'h005);
    do_load(3'd2, 12'h003);
    run_op(3'd1, 3'd7, 3'd1, 3'd2, 0, 3'd0, 12'h000, wb_cyc, nwb, o_rd, o_data, rdy_cyc, to);
    checks++;
    if (to || wb_cyc != 4 || o_rd !== 3'd7 || o_data !== 12'h008) begin
      errors++; $display("FAIL rstmid_next got cyc=%0d rd=%0d data=%03h want cyc=4 rd=7 data=008",
                         wb_cyc, o_rd, o_data);
    end
    read_reg(3'd7, d);
    checks++;
    if (d !== 12'h008) begin errors++; $display("FAIL rstmid_r7 got %03h want 008", d); end
  endtask

  // ---- sequence and report ----
  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    dbg_addr        = '0;
    test_reset();
    test_add();
    test_addc();
    test_hold_valid();
    test_collision();
    test_reset_mid();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
